conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_mac9.sv | 96 +++++++++
 rtl/conv3x3_engine.sv | 164 ++++++++++++++++
 tb/tb_conv3x3_engine.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine: default widths,
// kernel geometry, the control state encoding and the coefficient array type.
package conv_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int COEF_WIDTH   = 8;
  // 9 products of (DATA_WIDTH+1)x(COEF_WIDTH) bits plus 4 bits of growth
  // for the 9-term sum, so the accumulator can never overflow.
  localparam int ACC_WIDTH    = DATA_WIDTH + COEF_WIDTH + 5;
  localparam int KERNEL_WIDTH = 3;
  localparam int KERNEL_TAPS  = KERNEL_WIDTH * KERNEL_WIDTH;

  // Frame-level control: IDLE -> RUN -> DRAIN -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Coefficient k = 3*r + c (r = row from top, c = column from oldest).
  typedef logic signed [COEF_WIDTH-1:0] coef_arr_t [KERNEL_TAPS];

endpackage

// File: rtl/conv_mac9.sv
// Product and adder-tree stages of the 3x3 convolution.
// Stage 1 registers the nine signed products, stage 2 registers the
// shifted sum reduced to a pixel. Build option CONV_SATURATE_EN clamps the
// shifted sum to [0, 2^DATA_WIDTH-1]; without it the low bits are kept.
module conv_mac9 #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_valid,
  input  logic [9*DATA_WIDTH-1:0]            i_win,
  input  logic [9*COEF_WIDTH-1:0]            i_coef,
  output logic                               o_prod_valid,
  output logic                               o_valid,
  output logic [DATA_WIDTH-1:0]              o_pixel
);
  import conv_pkg::*;

  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 5;

  logic signed [ACC_W-1:0]      prod_d [KERNEL_TAPS];
  logic signed [ACC_W-1:0]      prod_q [KERNEL_TAPS];
  logic                         prod_vld_d, prod_vld_q;
  logic                         out_vld_d, out_vld_q;
  logic [DATA_WIDTH-1:0]        pix_d, pix_q;

  logic [DATA_WIDTH-1:0]        tap_pix;
  logic [COEF_WIDTH-1:0]        tap_coef;
  logic signed [ACC_W-1:0]      tap_px;
  logic signed [ACC_W-1:0]      tap_cf;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      shifted;

  // Stage 1: pixel is zero-extended, coefficient sign-extended, then multiplied.
  always_comb begin
    tap_pix  = '0;
    tap_coef = '0;
    tap_px   = '0;
    tap_cf   = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      tap_pix   = i_win[k*DATA_WIDTH +: DATA_WIDTH];
      tap_coef  = i_coef[k*COEF_WIDTH +: COEF_WIDTH];
      tap_px    = {{(ACC_W-DATA_WIDTH){1'b0}}, tap_pix};
      tap_cf    = {{(ACC_W-COEF_WIDTH){tap_coef[COEF_WIDTH-1]}}, tap_coef};
      prod_d[k] = tap_px * tap_cf;
    end
    prod_vld_d = i_valid;
  end

  // Stage 2: sum the products, shift, then clamp or truncate to a pixel.
  always_comb begin
    sum = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      sum = sum + prod_q[k];
    end
    shifted = sum >>> SHIFT;
`ifdef CONV_SATURATE_EN
    if (shifted[ACC_W-1]) begin
      pix_d = '0;
    end else if (shifted > ACC_W'((1 << DATA_WIDTH) - 1)) begin
      pix_d = '1;
    end else begin
      pix_d = DATA_WIDTH'(shifted);
    end
`else
    pix_d = DATA_WIDTH'(shifted);
`endif
    out_vld_d = prod_vld_q;
  end

  // Pipeline registers; reset empties both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        prod_q[k] <= '0;
      end
      prod_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      pix_q      <= '0;
    end else begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        prod_q[k] <= prod_d[k];
      end
      prod_vld_q <= prod_vld_d;
      out_vld_q  <= out_vld_d;
      pix_q      <= pix_d;
    end
  end

  assign o_prod_valid = prod_vld_q;
  assign o_valid      = out_vld_q;
  assign o_pixel      = pix_q;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 streaming convolution engine: column window, column/pass counters,
// frame FSM and kernel registers; arithmetic lives in conv_mac9.
// Build option CONV_SATURATE_EN selects clamped output (see conv_mac9).
// Handshake: a column is accepted on any cycle with i_valid high unless the
// FSM is in DRAIN; there is no back-pressure, o_valid is a one-cycle strobe.
module conv3x3_engine #(
  parameter int DATA_WIDTH   = conv_pkg::DATA_WIDTH,
  parameter int COEF_WIDTH   = conv_pkg::COEF_WIDTH,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int SHIFT        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic                  i_kernel_we,
  input  logic [3:0]            i_kernel_addr,
  input  logic [COEF_WIDTH-1:0] i_kernel_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [1:0]            o_dbg_state
);
  import conv_pkg::*;

  localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int PASS_W = (IMAGE_HEIGHT > 3) ? $clog2(IMAGE_HEIGHT - 2) : 1;
  localparam int WIN_W  = KERNEL_TAPS * DATA_WIDTH;
  localparam int KER_W  = KERNEL_TAPS * COEF_WIDTH;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(IMAGE_HEIGHT - 3);
  // Identity kernel: only the centre tap is 1.
  localparam logic [KER_W-1:0]  KERNEL_IDENT = KER_W'(1) << ((KERNEL_TAPS / 2) * COEF_WIDTH);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic                win_vld_q, win_vld_d;
  logic [KER_W-1:0]    coef_q, coef_d;

  logic                accept;
  logic                last_col;
  logic                last_pass;
  logic                frame_end;
  logic                pipe_empty;
  logic                prod_vld;
  logic                mac_valid;
  logic [DATA_WIDTH-1:0] col_in [KERNEL_WIDTH];

  // Column acceptance and frame position decode.
  always_comb begin
    accept     = i_valid && (state_q != DRAIN);
    last_col   = (col_q == COL_LAST);
    last_pass  = (pass_q == PASS_LAST);
    frame_end  = accept && last_col && last_pass;
    pipe_empty = !win_vld_q && !prod_vld && !mac_valid;
  end

  // Column and pass counters; a pass ends on its last accepted column.
  always_comb begin
    col_d  = col_q;
    pass_d = pass_q;
    if (accept) begin
      if (last_col) begin
        col_d  = '0;
        pass_d = last_pass ? '0 : pass_q + PASS_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
      end
    end
  end

  // Window shift: new column enters as column 2, column 0 falls out. A
  // window is only issued once three columns of the current pass are in.
  always_comb begin
    col_in[0] = i_data0;
    col_in[1] = i_data1;
    col_in[2] = i_data2;
    win_d     = win_q;
    if (accept) begin
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        win_d[(KERNEL_WIDTH*r)*DATA_WIDTH +: DATA_WIDTH]   = win_q[(KERNEL_WIDTH*r+1)*DATA_WIDTH +: DATA_WIDTH];
        win_d[(KERNEL_WIDTH*r+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(KERNEL_WIDTH*r+2)*DATA_WIDTH +: DATA_WIDTH];
        win_d[(KERNEL_WIDTH*r+2)*DATA_WIDTH +: DATA_WIDTH] = col_in[r];
      end
    end
    win_vld_d = accept && (col_q >= COL_W'(2));
  end

  // Kernel writes land only while idle, so a frame never sees a mixed kernel.
  always_comb begin
    coef_d = coef_q;
    if ((state_q == IDLE) && i_kernel_we && (i_kernel_addr < 4'(KERNEL_TAPS))) begin
      coef_d[i_kernel_addr*COEF_WIDTH +: COEF_WIDTH] = i_kernel_data;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      pass_q    <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      coef_q    <= KERNEL_IDENT;
    end else begin
      col_q     <= col_d;
      pass_q    <= pass_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      coef_q    <= coef_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN holds until every pipeline stage is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = frame_end ? DRAIN : RUN;
      RUN:     if (frame_end) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: frame_done coincides with the DRAIN -> IDLE transition.
  always_comb begin
    o_busy       = (state_q != IDLE);
    o_frame_done = (state_q == DRAIN) && pipe_empty;
    o_dbg_state  = state_q;
  end

  conv_mac9 #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .SHIFT      (SHIFT)
  ) u_mac (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (win_vld_q),
    .i_win        (win_q),
    .i_coef       (coef_q),
    .o_prod_valid (prod_vld),
    .o_valid      (mac_valid),
    .o_pixel      (o_pixel)
  );

  assign o_valid = mac_valid;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: scenario tasks drive frames, expected pixels and
// arrival cycles are queued at drive time and checked by the output monitor.
module tb_conv3x3_engine;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int IW = 10;
  localparam int IH = 10;
  localparam int SH = 0;
  localparam int NCOLS = IW * (IH - 2);
  localparam int NRES  = (IW - 2) * (IH - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [DW-1:0] i_data0, i_data1, i_data2;
  logic          i_kernel_we;
  logic [3:0]    i_kernel_addr;
  logic [CW-1:0] i_kernel_data;
  logic          o_valid;
  logic [DW-1:0] o_pixel;
  logic          o_busy;
  logic          o_frame_done;
  logic [1:0]    o_dbg_state;

  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            n_out, fd_cnt, fd_cyc, last_cyc, last_pix;
  int            kmodel[9];

  conv3x3_engine #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid),
    .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
    .i_kernel_we(i_kernel_we), .i_kernel_addr(i_kernel_addr), .i_kernel_data(i_kernel_data),
    .o_valid(o_valid), .o_pixel(o_pixel), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_dbg_state(o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: pop and compare on each o_valid, record frame_done pulses
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    int ec;
    if (o_valid === 1'b1) begin
      n_out++;
      last_cyc = cyc;
      last_pix = int'(o_pixel);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: o_pixel=%0d at cycle %0d, no result expected", o_pixel, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (o_pixel !== e) begin
          n_err++;
          $display("FAIL pixel: got %0d, expected %0d (cycle %0d)", o_pixel, e, cyc);
        end
        n_cmp++;
        if (cyc != ec) begin
          n_err++;
          $display("FAIL latency: o_valid at cycle %0d, expected cycle %0d", cyc, ec);
        end
      end
    end
    if (o_frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  function automatic int pix_at(int pat, int cval, int r, int c);
    return (pat == 0) ? (10 * r + c) : cval;
  endfunction

  // reference: result for the window ending at column col of pass p
  function automatic int model_out(int pat, int cval, int p, int col);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += kmodel[3*r+c] * pix_at(pat, cval, p + r, col - 2 + c);
    s = s >>> SH;
`ifdef CONV_SATURATE_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`else
    s = s & 255;
`endif
    return s;
  endfunction

  function automatic int sext8(int v);
    logic signed [7:0] t;
    t = 8'(v);
    return int'(t);
  endfunction

  // driver: ncols columns of a frame, optional random gaps, optional kernel
  // write on column we_at (we_takes says whether it should take effect)
  task automatic drive_frame(input int pat, input int cval, input int gap_max, input int ncols,
                             input int we_at, input int we_a, input int we_d, input bit we_takes);
    for (int idx = 0; idx < ncols; idx++) begin
      int p, c;
      p = idx / IW;
      c = idx % IW;
      @(negedge clk);
      if (idx == we_at) begin
        i_kernel_we   = 1'b1;
        i_kernel_addr = 4'(we_a);
        i_kernel_data = 8'(we_d);
        if (we_takes) kmodel[we_a] = sext8(we_d);
      end else begin
        i_kernel_we = 1'b0;
      end
      i_valid = 1'b1;
      i_data0 = 8'(pix_at(pat, cval, p, c));
      i_data1 = 8'(pix_at(pat, cval, p + 1, c));
      i_data2 = 8'(pix_at(pat, cval, p + 2, c));
      if (c >= 2) begin
        exp_q.push_back(8'(model_out(pat, cval, p, c)));
        exp_cyc_q.push_back(cyc + 3);
      end
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          i_valid     = 1'b0;
          i_kernel_we = 1'b0;
          i_data0     = 8'($urandom_range(0, 255));
          i_data1     = 8'($urandom_range(0, 255));
          i_data2     = 8'($urandom_range(0, 255));
        end
      end
    end
    @(negedge clk);
    i_valid     = 1'b0;
    i_kernel_we = 1'b0;
  endtask

  task automatic write_coef(input int a, input int dval, input bit takes);
    @(negedge clk);
    i_kernel_we   = 1'b1;
    i_kernel_addr = 4'(a);
    i_kernel_data = 8'(dval);
    @(negedge clk);
    i_kernel_we = 1'b0;
    if (takes) kmodel[a] = sext8(dval);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", o_valid); end
    n_cmp++; if (o_pixel !== 8'd0) begin n_err++; $display("FAIL reset_pixel: got %0d, expected 0", o_pixel); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
    n_cmp++; if (o_frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b, expected 0", o_frame_done); end
    n_cmp++; if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", o_dbg_state); end
    reset = 1'b0;
    for (int k = 0; k < 9; k++) kmodel[k] = (k == 4) ? 1 : 0;
  endtask

  task automatic test_identity_ramp();
    bit ok;
    n_out = 0; fd_cnt = 0;
    drive_frame(0, 0, 0, NCOLS, -1, 0, 0, 1'b0);
    // columns offered while draining must be ignored
    repeat (2) begin
      @(negedge clk);
      i_valid = 1'b1; i_data0 = 8'd200; i_data1 = 8'd201; i_data2 = 8'd202;
    end
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ident_timeout: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL ident_count: got %0d results, expected %0d", n_out, NRES); end
    n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL ident_done_count: got %0d pulses, expected 1", fd_cnt); end
    n_cmp++; if (fd_cyc != last_cyc + 1) begin n_err++; $display("FAIL ident_done_timing: pulse at %0d, expected %0d", fd_cyc, last_cyc + 1); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ident_leftover: %0d results missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_all_ones();
    bit ok;
    int want;
    for (int k = 0; k < 8; k++) write_coef(k, 1, 1'b1);
    n_out = 0; fd_cnt = 0;
    // last coefficient written together with the first column
    drive_frame(1, 30, 0, NCOLS, 0, 8, 1, 1'b1);
    wait_idle(ok);
`ifdef CONV_SATURATE_EN
    want = 255;
`else
    want = 14;
`endif
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ones_timeout: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL ones_count: got %0d, expected %0d", n_out, NRES); end
    n_cmp++; if (last_pix != want) begin n_err++; $display("FAIL ones_value: got %0d, expected %0d", last_pix, want); end
  endtask

  task automatic test_negative();
    bit ok;
    int want;
    write_coef(0, -1, 1'b1);
    for (int k = 1; k < 9; k++) write_coef(k, 0, 1'b1);
    n_out = 0; fd_cnt = 0;
    drive_frame(1, 5, 0, NCOLS, -1, 0, 0, 1'b0);
    wait_idle(ok);
`ifdef CONV_SATURATE_EN
    want = 0;
`else
    want = 251;
`endif
    n_cmp++; if (!ok) begin n_err++; $display("FAIL neg_timeout: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL neg_count: got %0d, expected %0d", n_out, NRES); end
    n_cmp++; if (last_pix != want) begin n_err++; $display("FAIL neg_value: got %0d, expected %0d", last_pix, want); end
  endtask

  task automatic test_kernel_ignore();
    bit ok;
    write_coef(0, 0, 1'b1);
    write_coef(4, 1, 1'b1);
    write_coef(13, 7, 1'b0);
    n_out = 0; fd_cnt = 0;
    drive_frame(0, 0, 0, NCOLS, 40, 4, 9, 1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL kwrite_timeout: busy still high, expected idle"); end
    n_out = 0; fd_cnt = 0;
    drive_frame(0, 0, 0, NCOLS, -1, 0, 0, 1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL kwrite_timeout2: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL kwrite_count: got %0d, expected %0d", n_out, NRES); end
    n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL kwrite_done: got %0d pulses, expected 1", fd_cnt); end
  endtask

  task automatic test_random_gaps();
    bit ok;
    n_out = 0; fd_cnt = 0;
    drive_frame(0, 0, 3, NCOLS, -1, 0, 0, 1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL gaps_timeout: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL gaps_count: got %0d, expected %0d", n_out, NRES); end
    n_cmp++; if (fd_cyc != last_cyc + 1) begin n_err++; $display("FAIL gaps_done_timing: pulse at %0d, expected %0d", fd_cyc, last_cyc + 1); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL gaps_leftover: %0d missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    write_coef(4, 2, 1'b1);
    drive_frame(0, 0, 0, 37, -1, 0, 0, 1'b0);
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) kmodel[k] = (k == 4) ? 1 : 0;
    n_out = 0; fd_cnt = 0;
    repeat (20) @(negedge clk);
    n_cmp++; if (n_out != 0) begin n_err++; $display("FAIL rst_mid_valid: got %0d results, expected 0", n_out); end
    n_cmp++; if (fd_cnt != 0) begin n_err++; $display("FAIL rst_mid_done: got %0d pulses, expected 0", fd_cnt); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b, expected 0", o_busy); end
    drive_frame(0, 0, 0, NCOLS, -1, 0, 0, 1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_mid_timeout: busy still high, expected idle"); end
    n_cmp++; if (n_out != NRES) begin n_err++; $display("FAIL rst_mid_count: got %0d, expected %0d", n_out, NRES); end
    n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL rst_mid_frame_done: got %0d pulses, expected 1", fd_cnt); end
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0;
    i_data0 = '0; i_data1 = '0; i_data2 = '0;
    i_kernel_we = 1'b0; i_kernel_addr = '0; i_kernel_data = '0;
    test_reset();
    test_identity_ramp();
    test_all_ones();
    test_negative();
    test_kernel_ignore();
    test_random_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
